rvtu_mul_offload: RTL and testbench



---
 rtl/rvtu_mul_offload_pkg.sv | 35 +++
 rtl/rvtu_mul_offload_if.sv | 47 ++++
 rtl/rvtu_mul_offload.sv | 126 ++++++++++++
 tb/tb_rvtu_mul_offload.sv | 379 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rvtu_mul_offload_pkg.sv
// Shared types for the RVTU multiply offload sequencer: PE packet format,
// multiply pids, operation encoding and sequencer states.
package rvtu_mul_offload_pkg;

    typedef logic [3:0] pid_t;

    typedef struct packed {
        pid_t        pid;
        logic [31:0] payload;
    } packet_t;

    localparam pid_t MUL_PID_OPA  = 4'd11;
    localparam pid_t MUL_PID_BASE = 4'd12;

    typedef enum logic [1:0] {
        MUL    = 2'd0,
        MULH   = 2'd1,
        MULHSU = 2'd2,
        MULHU  = 2'd3
    } mul_op_t;

    typedef enum logic [2:0] {
        IDLE,
        SEND_A,
        SEND_B,
        WAIT,
        RESP
    } mul_state_t;

    // Pattern-table entries 12..15 map one-to-one onto the four multiply flavours.
    function automatic pid_t mul_pid(input mul_op_t op);
        return MUL_PID_BASE + pid_t'(op);
    endfunction

endpackage

// File: rtl/rvtu_mul_offload_if.sv
// Core request/response channel plus the multiplier PE north-port FIFO pair,
// seen from the offload block (slave) and from its environment (master).
interface rvtu_mul_offload_if;
    import rvtu_mul_offload_pkg::*;

    logic        req_valid;
    logic        req_ready;
    mul_op_t     req_op;
    logic [31:0] req_a;
    logic [31:0] req_b;

    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic        rsp_err;

    logic        mul_eg_empty;
    logic        mul_eg_deq;
    packet_t     mul_eg_pkt;

    logic        mul_ig_empty;
    logic        mul_ig_deq;
    packet_t     mul_ig_pkt;

    modport slave (
        input  req_valid, req_op, req_a, req_b,
        output req_ready,
        output rsp_valid, rsp_data, rsp_err,
        input  rsp_ready,
        output mul_eg_empty, mul_eg_pkt,
        input  mul_eg_deq,
        input  mul_ig_empty, mul_ig_pkt,
        output mul_ig_deq
    );

    modport master (
        output req_valid, req_op, req_a, req_b,
        input  req_ready,
        input  rsp_valid, rsp_data, rsp_err,
        output rsp_ready,
        input  mul_eg_empty, mul_eg_pkt,
        output mul_eg_deq,
        output mul_ig_empty, mul_ig_pkt,
        input  mul_ig_deq
    );

endinterface

// File: rtl/rvtu_mul_offload.sv
// Sequencer turning one M-extension multiply into the {pid 11, a} / {pid 12+op, b}
// exchange with the multiplier PE and returning the PE result to the core.
module rvtu_mul_offload
    import rvtu_mul_offload_pkg::*;
#(
    parameter int TIMEOUT_CYC = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              init_done,
    rvtu_mul_offload_if.slave bus
);

    localparam int               CNT_W    = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    mul_state_t       state_q, state_d;
    mul_op_t          op_q;
    logic [31:0]      b_q;
    packet_t          eg_pkt_q;
    logic [CNT_W-1:0] cnt_q;
    logic [31:0]      rsp_data_q;
    logic             rsp_err_q;

    logic accept;
    logic eg_pop_a;
    logic eg_pop_b;
    logic ig_pop;
    logic timed_out;

    // NOTE: every signal driven here gets a default first, so no path through the case can infer a latch.
    always_comb begin
        state_d          = state_q;
        bus.req_ready    = 1'b0;
        bus.rsp_valid    = 1'b0;
        bus.mul_eg_empty = 1'b1;
        bus.mul_ig_deq   = 1'b0;
        accept           = 1'b0;
        eg_pop_a         = 1'b0;
        eg_pop_b         = 1'b0;
        ig_pop           = 1'b0;
        timed_out        = 1'b0;

        unique case (state_q)
            IDLE: begin
                bus.req_ready = init_done & ~rst;
                accept        = bus.req_valid & bus.req_ready;
                if (accept) state_d = SEND_A;
            end
            SEND_A: begin
                bus.mul_eg_empty = 1'b0;
                eg_pop_a         = bus.mul_eg_deq;
                if (eg_pop_a) state_d = SEND_B;
            end
            SEND_B: begin
                bus.mul_eg_empty = 1'b0;
                eg_pop_b         = bus.mul_eg_deq;
                if (eg_pop_b) state_d = WAIT;
            end
            WAIT: begin
                // Whatever arrives first is consumed; a late packet after timeout stays in the PE.
                bus.mul_ig_deq = ~bus.mul_ig_empty;
                ig_pop         = ~bus.mul_ig_empty;
                timed_out      = bus.mul_ig_empty & (cnt_q == CNT_LAST);
                if (ig_pop || timed_out) state_d = RESP;
            end
            RESP: begin
                bus.rsp_valid = 1'b1;
                if (bus.rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // NOTE: every register here is reset, since the packet and result outputs must read zero out of reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q       <= MUL;
            b_q        <= '0;
            eg_pkt_q   <= '0;
            cnt_q      <= '0;
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b0;
        end else begin
            if (accept) begin
                op_q             <= bus.req_op;
                b_q              <= bus.req_b;
                eg_pkt_q.pid     <= MUL_PID_OPA;
                eg_pkt_q.payload <= bus.req_a;
            end else if (eg_pop_a) begin
                eg_pkt_q.pid     <= mul_pid(op_q);
                eg_pkt_q.payload <= b_q;
            end

            if (eg_pop_b)              cnt_q <= '0;
            else if (state_q == WAIT)  cnt_q <= cnt_q + 1'b1;

            if (ig_pop) begin
                if (bus.mul_ig_pkt.pid == mul_pid(op_q)) begin
                    rsp_data_q <= bus.mul_ig_pkt.payload;
                    rsp_err_q  <= 1'b0;
                end else begin
                    rsp_data_q <= '0;
                    rsp_err_q  <= 1'b1;
                end
            end else if (timed_out) begin
                rsp_data_q <= '0;
                rsp_err_q  <= 1'b1;
            end else if (state_q == RESP && bus.rsp_ready) begin
                rsp_data_q <= '0;
                rsp_err_q  <= 1'b0;
            end
        end
    end

    assign bus.mul_eg_pkt = eg_pkt_q;
    assign bus.rsp_data   = rsp_data_q;
    assign bus.rsp_err    = rsp_err_q;

endmodule

// File: tb/tb_rvtu_mul_offload.sv
// Bench for rvtu_mul_offload: a behavioural multiplier PE answers the two-packet
// exchange, and results are compared with plain 64-bit arithmetic.
module tb_rvtu_mul_offload;
    import rvtu_mul_offload_pkg::*;

    localparam int TMO = 8;

    logic clk       = 1'b0;
    logic rst       = 1'b1;
    logic init_done = 1'b0;
    int   cyc       = 0;
    int   n_cmp     = 0;
    int   n_bad     = 0;

    // PE model knobs and observations
    int      eg_delay     = 0;
    int      rsp_delay    = 0;
    int      rsp_mode     = 0;   // 0 answer, 1 silent, 2 answer with pid 13
    bit      spurious_deq = 1'b0;
    bit      pe_clear     = 1'b0;
    packet_t eg_log[$];
    int      hold_bad     = 0;
    int      ig_pops      = 0;
    int      ig_bad       = 0;
    int      accept_wait  = 0;

    rvtu_mul_offload_if bus();

    rvtu_mul_offload #(.TIMEOUT_CYC(TMO)) dut (
        .clk       (clk),
        .rst       (rst),
        .init_done (init_done),
        .bus       (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] ref_mul(input int op, input logic [31:0] a, input logic [31:0] b);
        longint unsigned sa, sb, ua, ub, p;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        ua = {32'd0, a};
        ub = {32'd0, b};
        case (op)
            0:       p = ua * ub;
            1:       p = sa * sb;
            2:       p = sa * ub;
            default: p = ua * ub;
        endcase
        return (op == 0) ? p[31:0] : p[63:32];
    endfunction

    // Behavioural PE: pops presented packets after eg_delay cycles, answers rsp_delay cycles after operand b.
    initial begin : pe_model
        int          eg_wait;
        int          pend;
        bit          have_held;
        bit          ig_popped;
        packet_t     held;
        packet_t     rsp;
        logic [31:0] opa;
        eg_wait = 0; pend = -1; have_held = 0; ig_popped = 0; opa = '0; held = '0; rsp = '0;
        bus.mul_eg_deq   = 1'b0;
        bus.mul_ig_empty = 1'b1;
        bus.mul_ig_pkt   = '0;
        forever begin
            @(negedge clk);
            if (rst || pe_clear) begin
                eg_wait = 0; pend = -1; have_held = 0; ig_popped = 0;
                bus.mul_eg_deq   = 1'b0;
                bus.mul_ig_empty = 1'b1;
                bus.mul_ig_pkt   = '0;
                continue;
            end
            if (ig_popped) bus.mul_ig_empty = 1'b1;
            if (pend == 0) begin
                bus.mul_ig_pkt   = rsp;
                bus.mul_ig_empty = 1'b0;
                pend = -1;
            end else if (pend > 0) begin
                pend--;
            end
            bus.mul_eg_deq = 1'b0;
            if (bus.mul_eg_empty === 1'b0) begin
                if (have_held && bus.mul_eg_pkt !== held) hold_bad++;
                held = bus.mul_eg_pkt;
                have_held = 1;
                if (eg_wait >= eg_delay) begin
                    bus.mul_eg_deq = 1'b1;
                    eg_log.push_back(held);
                    have_held = 0;
                    eg_wait = 0;
                    if (held.pid == MUL_PID_OPA) begin
                        opa = held.payload;
                    end else begin
                        rsp.pid     = (rsp_mode == 2) ? 4'd13 : held.pid;
                        rsp.payload = ref_mul(int'(held.pid) - 12, opa, held.payload);
                        pend        = (rsp_mode == 1) ? -1 : rsp_delay;
                    end
                end else begin
                    eg_wait++;
                end
            end else begin
                have_held = 0;
                bus.mul_eg_deq = spurious_deq;
            end
            #1;
            ig_popped = bus.mul_ig_deq && !bus.mul_ig_empty;
            if (ig_popped) ig_pops++;
            if (bus.mul_ig_deq && bus.mul_ig_empty) ig_bad++;
        end
    end

    // One full transaction, entered and left on a falling edge.
    task automatic do_txn(input string name, input int op, input logic [31:0] a, input logic [31:0] b,
                          input int hold, input bit drop_init, input logic [31:0] exp_data,
                          input logic exp_err, input int exp_lat, input int exp_pops);
        int          k;
        int          t0;
        int          lat;
        logic [31:0] data;
        logic        err;
        packet_t     pa;
        packet_t     pb;
        pa.pid = MUL_PID_OPA;  pa.payload = a;
        pb.pid = 4'(12 + op);  pb.payload = b;
        eg_log.delete();
        hold_bad = 0; ig_pops = 0; ig_bad = 0;
        bus.req_valid = 1'b1;
        bus.req_op    = mul_op_t'(op);
        bus.req_a     = a;
        bus.req_b     = b;
        k = 0;
        while (bus.req_ready !== 1'b1 && k < 50) begin @(negedge clk); k++; end
        accept_wait = k;
        n_cmp++;
        if (bus.req_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL %s accept: req_ready=%b required 1 within 50 cycles", name, bus.req_ready);
            bus.req_valid = 1'b0;
            return;
        end
        t0 = cyc;
        @(negedge clk);
        // Garbage on the request inputs while busy must not disturb the transaction.
        bus.req_valid = 1'($urandom_range(1));
        bus.req_op    = mul_op_t'($urandom_range(3));
        bus.req_a     = $urandom;
        bus.req_b     = $urandom;
        if (drop_init) init_done = 1'b0;
        k = 0;
        while (bus.rsp_valid !== 1'b1 && k < 200) begin @(negedge clk); k++; end
        init_done = 1'b1;
        n_cmp++;
        if (bus.rsp_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL %s response: rsp_valid=%b required 1 within 200 cycles", name, bus.rsp_valid);
            bus.req_valid = 1'b0;
            return;
        end
        lat  = cyc - t0;
        data = bus.rsp_data;
        err  = bus.rsp_err;
        n_cmp++;
        if ({err, data} !== {exp_err, exp_data}) begin
            n_bad++;
            $display("FAIL %s result: err=%b data=%h required err=%b data=%h", name, err, data, exp_err, exp_data);
        end
        if (exp_lat >= 0) begin
            n_cmp++;
            if (lat != exp_lat) begin
                n_bad++;
                $display("FAIL %s latency: %0d cycles required %0d", name, lat, exp_lat);
            end
        end
        n_cmp++;
        if (eg_log.size() != 2 || eg_log[0] !== pa || eg_log[1] !== pb) begin
            n_bad++;
            $display("FAIL %s pe_packets: got %0d pops first=%h required 2 pops %h,%h",
                     name, eg_log.size(), (eg_log.size() > 0) ? eg_log[0] : '0, pa, pb);
        end
        repeat (hold) begin
            @(negedge clk);
            n_cmp++;
            if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== data || bus.rsp_err !== err) begin
                n_bad++;
                $display("FAIL %s rsp_hold: valid=%b data=%h err=%b required 1 %h %b",
                         name, bus.rsp_valid, bus.rsp_data, bus.rsp_err, data, err);
            end
        end
        bus.req_valid = 1'b1;
        bus.rsp_ready = 1'b1;
        n_cmp++;
        if (bus.req_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL %s ready_during_ack: req_ready=%b required 0", name, bus.req_ready);
        end
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        bus.req_valid = 1'b0;
        n_cmp++;
        if (bus.rsp_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL %s rsp_drop: rsp_valid=%b required 0", name, bus.rsp_valid);
        end
        n_cmp++;
        if (hold_bad != 0 || ig_pops != exp_pops || ig_bad != 0) begin
            n_bad++;
            $display("FAIL %s pe_side: unstable=%0d ig_pops=%0d bad_deq=%0d required 0 %0d 0",
                     name, hold_bad, ig_pops, ig_bad, exp_pops);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; init_done = 1'b1;
        bus.req_valid = 1'b1; bus.req_op = MUL; bus.req_a = 32'd5; bus.req_b = 32'd5;
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({bus.req_ready, bus.rsp_valid, bus.rsp_err, bus.rsp_data, bus.mul_eg_empty, bus.mul_eg_pkt, bus.mul_ig_deq}
            !== {3'b000, 32'd0, 1'b1, 36'd0, 1'b0}) begin
            n_bad++;
            $display("FAIL reset_outputs: rdy=%b vld=%b err=%b data=%h eg_empty=%b pkt=%h ig_deq=%b required 0 0 0 0 1 0 0",
                     bus.req_ready, bus.rsp_valid, bus.rsp_err, bus.rsp_data, bus.mul_eg_empty, bus.mul_eg_pkt, bus.mul_ig_deq);
        end
        init_done = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        repeat (10) begin
            @(negedge clk);
            n_cmp++;
            if (bus.req_ready !== 1'b0 || bus.mul_eg_empty !== 1'b1) begin
                n_bad++;
                $display("FAIL init_gating: req_ready=%b eg_empty=%b required 0 1", bus.req_ready, bus.mul_eg_empty);
            end
        end
        bus.req_valid = 1'b0;
        init_done = 1'b1;
        #1;
        n_cmp++;
        if (bus.req_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL ready_after_init: req_ready=%b required 1", bus.req_ready);
        end
        @(negedge clk);
    endtask

    task automatic test_mul_basic();
        do_txn("mul_7x6", 0, 32'd7, 32'd6, 0, 0, 32'd42, 1'b0, 4, 1);
    endtask

    task automatic test_mulh_variants();
        do_txn("mulh",   1, 32'hFFFF_FFFF, 32'd2, 0, 0, 32'hFFFF_FFFF, 1'b0, 4, 1);
        do_txn("mulhsu", 2, 32'hFFFF_FFFF, 32'd2, 0, 0, 32'hFFFF_FFFF, 1'b0, 4, 1);
        do_txn("mulhu",  3, 32'hFFFF_FFFF, 32'd2, 0, 0, 32'h0000_0001, 1'b0, 4, 1);
    endtask

    task automatic test_backpressure();
        eg_delay = 5; spurious_deq = 1'b1;
        do_txn("backpressure", 1, 32'h8000_0001, 32'h7FFF_FFFF, 3, 1,
               ref_mul(1, 32'h8000_0001, 32'h7FFF_FFFF), 1'b0, 2 * 5 + 4, 1);
        eg_delay = 0; spurious_deq = 1'b0;
    endtask

    task automatic test_timeout();
        rsp_mode = 1;
        do_txn("timeout", 0, 32'd3, 32'd4, 0, 0, 32'd0, 1'b1, 3 + TMO, 0);
        rsp_mode = 0; rsp_delay = TMO + 2;
        do_txn("late_rsp", 3, 32'hDEAD_BEEF, 32'h1234_5678, 0, 0, 32'd0, 1'b1, 3 + TMO, 0);
        repeat (5) @(negedge clk);
        n_cmp++;
        if (ig_pops != 0 || bus.mul_ig_empty !== 1'b0) begin
            n_bad++;
            $display("FAIL late_not_popped: pops=%0d ig_empty=%b required 0 0", ig_pops, bus.mul_ig_empty);
        end
        pe_clear = 1'b1;
        @(negedge clk);
        @(negedge clk);
        pe_clear = 1'b0; rsp_delay = 0;
        do_txn("after_timeout", 2, 32'hFFFF_FFF0, 32'd100, 0, 0,
               ref_mul(2, 32'hFFFF_FFF0, 32'd100), 1'b0, 4, 1);
    endtask

    task automatic test_pid_mismatch();
        rsp_mode = 2;
        do_txn("pid_mismatch", 0, 32'd9, 32'd9, 1, 0, 32'd0, 1'b1, 4, 1);
        rsp_mode = 0;
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 4; i++) begin
            int          op;
            logic [31:0] a;
            logic [31:0] b;
            op = $urandom_range(3); a = $urandom; b = $urandom;
            do_txn("back_to_back", op, a, b, 0, 0, ref_mul(op, a, b), 1'b0, 4, 1);
            if (i > 0) begin
                n_cmp++;
                if (accept_wait != 0) begin
                    n_bad++;
                    $display("FAIL b2b_turnaround: waited %0d cycles for req_ready required 0", accept_wait);
                end
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 20; i++) begin
            int          op;
            logic [31:0] a;
            logic [31:0] b;
            op = $urandom_range(3); a = $urandom; b = $urandom;
            eg_delay = $urandom_range(3); rsp_delay = $urandom_range(3);
            spurious_deq = 1'($urandom_range(1));
            do_txn("random", op, a, b, $urandom_range(2), 1'($urandom_range(1)),
                   ref_mul(op, a, b), 1'b0, 2 * eg_delay + 4 + rsp_delay, 1);
        end
        eg_delay = 0; rsp_delay = 0; spurious_deq = 1'b0;
    endtask

    task automatic test_mid_reset();
        int k;
        eg_delay = 3;
        bus.req_valid = 1'b1; bus.req_op = MULHU; bus.req_a = 32'h55; bus.req_b = 32'h66;
        k = 0;
        while (bus.req_ready !== 1'b1 && k < 50) begin @(negedge clk); k++; end
        @(negedge clk);
        bus.req_valid = 1'b0;
        k = 0;
        while (!(bus.mul_eg_empty === 1'b0 && bus.mul_eg_pkt.pid === 4'd15) && k < 50) begin
            @(negedge clk); k++;
        end
        n_cmp++;
        if (k >= 50) begin
            n_bad++;
            $display("FAIL reach_send_b: pkt=%h eg_empty=%b required pid f presented", bus.mul_eg_pkt, bus.mul_eg_empty);
        end
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if ({bus.mul_eg_empty, bus.mul_eg_pkt, bus.rsp_valid, bus.mul_ig_deq, bus.req_ready} !== {1'b1, 36'd0, 3'b000}) begin
            n_bad++;
            $display("FAIL mid_reset: eg_empty=%b pkt=%h vld=%b ig_deq=%b rdy=%b required 1 0 0 0 0",
                     bus.mul_eg_empty, bus.mul_eg_pkt, bus.rsp_valid, bus.mul_ig_deq, bus.req_ready);
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_cmp++;
        if (bus.req_ready !== 1'b1 || bus.mul_eg_empty !== 1'b1) begin
            n_bad++;
            $display("FAIL idle_after_reset: req_ready=%b eg_empty=%b required 1 1", bus.req_ready, bus.mul_eg_empty);
        end
        @(negedge clk);
        eg_delay = 0;
        do_txn("post_reset", 0, 32'd1000, 32'd1000, 0, 0, 32'd1_000_000, 1'b0, 4, 1);
    endtask

    initial begin
        bus.req_valid = 1'b0;
        bus.req_op    = MUL;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.rsp_ready = 1'b0;
        test_reset();
        test_mul_basic();
        test_mulh_variants();
        test_backpressure();
        test_timeout();
        test_pid_mismatch();
        test_back_to_back();
        test_random();
        test_mid_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
